// File: rtl/demux_1_to_4_scheduler_if.sv
// Producer/consumer bundle for the 1-to-4 demux scheduler: one input stream,
// four output channels sharing a data bus, plus the scheduler's status outputs.
interface demux_1_to_4_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  mode;
  logic [3:0]            enable_mask;
  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_dest;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [1:0]            select_lines;
  logic [CNT_WIDTH-1:0]  drop_count;
  logic                  busy;

  modport master (
    output mode, enable_mask, in_data, in_dest, in_valid, out_ready,
    input  in_ready, out_data, out_valid, select_lines, drop_count, busy
  );

  modport slave (
    input  mode, enable_mask, in_data, in_dest, in_valid, out_ready,
    output in_ready, out_data, out_valid, select_lines, drop_count, busy
  );
endinterface

// File: rtl/demux_1_to_4_scheduler.sv
// Distributes a valid/ready word stream over four channels, round-robin over
// enabled channels or by per-word destination, with saturating drop accounting.
module demux_1_to_4_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  demux_1_to_4_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sel_q;
  logic [1:0]            rr_ptr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  drop_q;
  logic                  held_mode_q;

  logic [1:0] ptr_eff;
  logic [1:0] target;
  logic       rr_stall;
  logic       complete;
  logic       ready;
  logic       accept;
  logic       drop;
  logic       load;

  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    rr_stall = !bus.mode && (bus.enable_mask == 4'b0000);
    complete = (state_q == SEND) && bus.out_ready[sel_q];
    ready    = !rr_stall && ((state_q == IDLE) || bus.out_ready[sel_q]);
    accept   = bus.in_valid && ready;
    // A word accepted on a completing edge must see the pointer as it is about to become
    ptr_eff  = (complete && !held_mode_q) ? sel_q + 2'd1 : rr_ptr_q;
    target   = bus.mode ? bus.in_dest : rr_pick(bus.enable_mask, ptr_eff);
    drop     = accept && bus.mode && !bus.enable_mask[bus.in_dest];
    load     = accept && !drop;

    state_d = state_q;
    if (load) begin
      state_d = SEND;
    end else if (complete || drop) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 2'b00;
      rr_ptr_q    <= 2'b00;
      data_q      <= '0;
      drop_q      <= '0;
      held_mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q      <= bus.in_data;
        sel_q       <= target;
        held_mode_q <= bus.mode;
      end
      if (complete && !held_mode_q) begin
        rr_ptr_q <= sel_q + 2'd1;
      end
      if (drop) begin
        drop_q <= sat_inc(drop_q);
      end
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_data     = data_q;
  assign bus.select_lines = sel_q;
  assign bus.out_valid    = (state_q == SEND) ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.drop_count   = drop_q;
  assign bus.busy         = (state_q == SEND);

endmodule

// File: tb/tb_demux_1_to_4_scheduler.sv
// Directed bench for demux_1_to_4_scheduler with hand-computed expectations.
module tb_demux_1_to_4_scheduler;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   t2_ch[4] = '{1, 3, 1, 3};

  demux_1_to_4_scheduler_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

  demux_1_to_4_scheduler #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.mode        = 1'b0;
    bus.enable_mask = 4'b1111;
    bus.in_data     = 8'h00;
    bus.in_dest     = 2'd0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_out_valid", bus.out_valid, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_drop", bus.drop_count, 8'd0);
    chk("rst_sel", bus.select_lines, 2'd0);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Round-robin streaming over all four channels
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA0 + 8'(i);
      #1;
      chk("t1_in_ready", bus.in_ready, 1'b1);
      tick();
      chk("t1_sel", bus.select_lines, 32'(i % 4));
      chk("t1_out_valid", bus.out_valid, 32'(4'b0001 << (i % 4)));
      chk("t1_data", bus.out_data, 32'(8'hA0 + i));
      chk("t1_busy", bus.busy, 1'b1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t1_end_valid", bus.out_valid, 4'b0000);
    chk("t1_end_busy", bus.busy, 1'b0);
    chk("t1_end_sel", bus.select_lines, 2'd1);
    chk("t1_end_data", bus.out_data, 8'hA5);

    // Round-robin over a sparse mask, then an empty mask stalls
    do_reset();
    bus.enable_mask = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h50 + 8'(i);
      tick();
      chk("t2_sel", bus.select_lines, 32'(t2_ch[i]));
      chk("t2_out_valid", bus.out_valid, 32'(4'b0001 << t2_ch[i]));
    end
    bus.in_valid = 1'b0;
    tick();
    bus.enable_mask = 4'b0000;
    bus.in_valid    = 1'b1;
    #1;
    chk("t2_stall_ready", bus.in_ready, 1'b0);
    tick();
    chk("t2_stall_busy", bus.busy, 1'b0);
    chk("t2_stall_drop", bus.drop_count, 8'd0);
    bus.in_valid = 1'b0;

    // Directed mode with drops to a disabled channel
    bus.mode        = 1'b1;
    bus.enable_mask = 4'b0111;
    bus.in_valid    = 1'b1;
    bus.in_dest     = 2'd3;
    bus.in_data     = 8'h11;
    tick();
    chk("t3_drop1", bus.drop_count, 8'd1);
    chk("t3_drop1_valid", bus.out_valid, 4'b0000);
    bus.in_dest = 2'd2;
    bus.in_data = 8'h22;
    tick();
    chk("t3_ch2_valid", bus.out_valid, 4'b0100);
    chk("t3_ch2_data", bus.out_data, 8'h22);
    chk("t3_ch2_drop", bus.drop_count, 8'd1);
    bus.in_dest = 2'd3;
    bus.in_data = 8'h33;
    tick();
    chk("t3_drop2", bus.drop_count, 8'd2);
    chk("t3_drop2_valid", bus.out_valid, 4'b0000);
    chk("t3_drop2_data", bus.out_data, 8'h22);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) chk("t3_drop_102", bus.drop_count, 8'd102);
    end
    chk("t3_drop_sat", bus.drop_count, 8'd255);
    chk("t3_sat_busy", bus.busy, 1'b0);

    // Backpressure on the held channel; other channels' readies ignored
    bus.enable_mask = 4'b1111;
    bus.out_ready   = 4'b0001;
    bus.in_dest     = 2'd1;
    bus.in_data     = 8'h5C;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", bus.out_valid, 4'b0010);
      chk("t4_hold_data", bus.out_data, 8'h5C);
      chk("t4_hold_ready", bus.in_ready, 1'b0);
      tick();
    end
    bus.out_ready = 4'b1111;
    #1;
    chk("t4_release_ready", bus.in_ready, 1'b1);
    tick();
    chk("t4_done_valid", bus.out_valid, 4'b0000);
    chk("t4_done_busy", bus.busy, 1'b0);

    // Mask drops the held channel mid-SEND; delivery continues, RR moves on
    do_reset();
    bus.mode        = 1'b0;
    bus.enable_mask = 4'b1111;
    bus.out_ready   = 4'b1111;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'hB0 + 8'(i);
      tick();
    end
    chk("t5_sel2", bus.select_lines, 2'd2);
    bus.in_valid    = 1'b0;
    bus.out_ready   = 4'b1011;
    bus.enable_mask = 4'b1011;
    tick();
    tick();
    chk("t5_hold_valid", bus.out_valid, 4'b0100);
    chk("t5_hold_data", bus.out_data, 8'hB2);
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hB3;
    tick();
    chk("t5_next_sel", bus.select_lines, 2'd3);
    chk("t5_next_valid", bus.out_valid, 4'b1000);
    chk("t5_next_data", bus.out_data, 8'hB3);
    bus.in_valid = 1'b0;
    tick();

    // Asynchronous reset mid-SEND
    bus.mode        = 1'b1;
    bus.enable_mask = 4'b1110;
    bus.in_dest     = 2'd0;
    bus.in_valid    = 1'b1;
    tick();
    chk("t6_pre_drop", bus.drop_count, 8'd1);
    bus.mode        = 1'b0;
    bus.enable_mask = 4'b1111;
    bus.in_data     = 8'hC0;
    tick();
    bus.in_data = 8'hC1;
    tick();
    chk("t6_pre_sel", bus.select_lines, 2'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.out_valid, 4'b0000);
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_drop", bus.drop_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_post_busy", bus.busy, 1'b0);
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hD0;
    tick();
    chk("t6_first_sel", bus.select_lines, 2'd0);
    chk("t6_first_valid", bus.out_valid, 4'b0001);
    chk("t6_first_data", bus.out_data, 8'hD0);
    bus.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1_to_4_scheduler.md
Name: demux_1_to_4_scheduler

Overview:
Sequencing controller that distributes a valid/ready input word stream across four output channels through a 1-to-4 demultiplex point. It drives the 2-bit select lines and a one-hot per-channel valid. Targets are chosen either round-robin over enabled channels or by a per-word destination field. It sits between a single producer and four consumers, and owns channel enable, arbitration and drop accounting.

Parameters:
DATA_WIDTH, 8, width of each data word
CNT_WIDTH, 8, width of the saturating drop counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = round-robin, 1 = directed (use in_dest)
enable_mask  input  4  bit i = 1 means channel i may receive words
in_data  input  DATA_WIDTH  input word
in_dest  input  2  destination channel, used only when mode = 1
in_valid  input  1  producer has a word
in_ready  output  1  scheduler accepts the word this cycle
out_data  output  DATA_WIDTH  held word, shared by all channels
out_valid  output  4  one-hot valid, bit = select_lines
out_ready  input  4  per-channel consumer ready
select_lines  output  2  current target channel, drives the demux
drop_count  output  CNT_WIDTH  directed words discarded to disabled channels
busy  output  1  high while a word is held (state SEND)

Behaviour:
- Reset (rst_n = 0, asynchronous): state IDLE, out_valid = 4'b0000, out_data = 0, select_lines = 2'b00, round-robin pointer rr_ptr = 0, drop_count = 0, busy = 0. Reset mid-SEND discards the held word with no delivery.
- Accept = in_valid & in_ready, sampled on the rising edge. mode and enable_mask are sampled only at accept.
- Target selection at accept:
  - RR mode: first set bit of enable_mask searching rr_ptr, rr_ptr+1, ... modulo 4.
  - Directed mode: target = in_dest.
- Drop: in directed mode with enable_mask[in_dest] = 0, the word is accepted and discarded. drop_count increments and saturates at all-ones. State becomes or stays IDLE, and nothing is driven.
- IDLE state:
  - busy = 0, out_valid = 0.
  - in_ready = 1, except in RR mode with enable_mask = 0, where in_ready = 0 (stall, no drop).
  - On a non-drop accept: out_data <= in_data, select_lines <= target, go to SEND.
- SEND state:
  - busy = 1, out_valid[select_lines] = 1, other bits 0.
  - in_ready = out_ready[select_lines] (RR stall rule above still applies).
  - Completion when out_ready[select_lines] = 1. In RR mode the completing edge sets rr_ptr <= select_lines + 1 (mod 4). Directed completion does not move rr_ptr.
  - Completion with a simultaneous accept: the new target is computed using the updated rr_ptr. For a non-drop word, load it and stay in SEND, giving back-to-back delivery at 1 word/cycle. For a drop word, go to IDLE.
  - Completion without accept: go to IDLE.
  - No completion: hold out_data, select_lines and out_valid stable. Readies on non-selected channels are ignored.
- Latency: a word accepted at edge N is presented (out_valid high) in the cycle after edge N.
- enable_mask falling for the held channel during SEND does not cancel delivery.
- After completion, out_data and select_lines keep their last values and out_valid returns to 0.
- Arithmetic: rr_ptr and select_lines are 2-bit and wrap 3 -> 0. drop_count never wraps.

Test Plan:
- Reset, RR mode, mask 4'b1111, out_ready 4'b1111, words 0xA0..0xA5 streamed -> select_lines 0,1,2,3,0,1; out_valid 0001,0010,0100,1000,0001,0010; one word/cycle after the first; in_ready stays 1.
- RR mode, mask 4'b1010, 4 words -> delivered to channels 1,3,1,3. Then mask 4'b0000 -> in_ready = 0 and drop_count unchanged.
- Directed mode, mask 4'b0111, dest sequence 3,2,3 with data 0x11,0x22,0x33 -> 0x11 and 0x33 dropped, drop_count = 2, 0x22 delivered on channel 2 only. Then 300 drops -> drop_count saturates at 255.
- Backpressure: directed dest 1, out_ready[1] = 0 for 5 cycles while out_ready[0] = 1 -> out_valid = 0010 and out_data held for 5 cycles, in_ready = 0. Release -> completes next edge.
- Mask clears channel 2 during SEND on channel 2 -> word still delivered to channel 2. The next RR word goes to channel 3 (if enabled).
- Assert rst_n low mid-SEND (asynchronously, between edges) -> out_valid = 0, busy = 0 and drop_count = 0 immediately. After release, the first RR word goes to channel 0.
